// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesting units and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter_if #(
   parameter int N = 4
) ();
   logic                 en;
   logic [N-1:0]         req;
   logic                 done;
   logic [N-1:0]         gnt;
   logic                 busy;
   logic [$clog2(N)-1:0] owner_id;
   logic                 timeout;

   modport master (
      output en, req, done,
      input  gnt, busy, owner_id, timeout
   );

   modport slave (
      input  en, req, done,
      output gnt, busy, owner_id, timeout
   );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with multi-cycle ownership and a hold watchdog; grant is registered,
// 1 cycle after req is sampled, with a forced idle bubble after every release.
module rr_arbiter #(
   parameter int N        = 4,
   parameter int HOLD_MAX = 16
) (
   input  logic        clock,
   input  logic        reset,
   rr_arbiter_if.slave bus
);
   localparam int               CNT_W   = $clog2(HOLD_MAX + 1);
   localparam int               IDX_W   = $clog2(N);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [N-1:0]     OH_ONE  = N'(1);

   typedef enum logic {
      ST_IDLE,
      ST_GRANT
   } state_t;

   state_t           r_state;
   logic [N-1:0]     r_gnt;
   logic [IDX_W-1:0] r_owner;
   logic [IDX_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;

   state_t           w_state_nxt;
   logic [N-1:0]     w_gnt_nxt;
   logic [IDX_W-1:0] w_owner_nxt;
   logic [IDX_W-1:0] w_ptr_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_timeout_nxt;

   logic             w_win_found;
   logic [IDX_W-1:0] w_win_idx;
   logic [IDX_W-1:0] w_cand;
   logic             w_owner_req;
   logic             w_hold_max;
   logic             w_release;

   // r_ptr is the last owner: search starts just below it and wraps, so it is visited last.
   always_comb begin
      w_win_found = 1'b0;
      w_win_idx   = '0;
      w_cand      = '0;
      for (int i = 1; i <= N; i++) begin
         if (int'(r_ptr) >= i) begin
            w_cand = IDX_W'(int'(r_ptr) - i);
         end else begin
            w_cand = IDX_W'(int'(r_ptr) + N - i);
         end
         if (!w_win_found && bus.req[w_cand]) begin
            w_win_found = 1'b1;
            w_win_idx   = w_cand;
         end
      end
   end

   assign w_owner_req = bus.req[r_owner];
   assign w_hold_max  = (r_cnt == CNT_MAX);
   assign w_release   = !bus.en || bus.done || !w_owner_req || w_hold_max;

   always_comb begin
      w_state_nxt   = r_state;
      w_gnt_nxt     = r_gnt;
      w_owner_nxt   = r_owner;
      w_ptr_nxt     = r_ptr;
      w_cnt_nxt     = r_cnt;
      w_timeout_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.en && w_win_found) begin
               w_gnt_nxt   = OH_ONE << w_win_idx;
               w_owner_nxt = w_win_idx;
               w_cnt_nxt   = CNT_ONE;
               w_state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (w_release) begin
               w_gnt_nxt     = '0;
               w_ptr_nxt     = r_owner;
               w_cnt_nxt     = '0;
               w_state_nxt   = ST_IDLE;
               // Watchdog is only blamed when nothing else would have released the grant.
               w_timeout_nxt = w_hold_max && bus.en && !bus.done && w_owner_req;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_gnt_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_gnt     <= '0;
         r_owner   <= '0;
         r_ptr     <= '0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_owner   <= w_owner_nxt;
         r_ptr     <= w_ptr_nxt;
         r_cnt     <= w_cnt_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign bus.gnt      = r_gnt;
   assign bus.busy     = |r_gnt;
   assign bus.owner_id = r_owner;
   assign bus.timeout  = r_timeout;
endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: one instance with HOLD_MAX=16 for rotation/enable/request-drop,
// one with HOLD_MAX=4 for watchdog, simultaneous release and async reset mid-grant.
module tb_rr_arbiter;
   logic clock;
   logic reset;
   int   n_vec;
   int   n_err;

   rr_arbiter_if #(.N(4)) bus16 ();
   rr_arbiter_if #(.N(4)) bus4 ();

   rr_arbiter #(.N(4), .HOLD_MAX(16)) u_dut16 (
      .clock (clock),
      .reset (reset),
      .bus   (bus16)
   );

   rr_arbiter #(.N(4), .HOLD_MAX(4)) u_dut4 (
      .clock (clock),
      .reset (reset),
      .bus   (bus4)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int win [5];
      win   = '{3, 2, 1, 0, 3};
      n_vec = 0;
      n_err = 0;

      reset = 1'b1;
      bus16.en = 1'b0; bus16.req = 4'b0000; bus16.done = 1'b0;
      bus4.en  = 1'b0; bus4.req  = 4'b0000; bus4.done  = 1'b0;
      #3;
      chk("rst_gnt",     32'(bus16.gnt),      32'h0);
      chk("rst_busy",    32'(bus16.busy),     32'h0);
      chk("rst_owner",   32'(bus16.owner_id), 32'h0);
      chk("rst_timeout", 32'(bus16.timeout),  32'h0);
      chk("rst_gnt4",    32'(bus4.gnt),       32'h0);
      step();
      step();
      reset = 1'b0;

      // Round-robin rotation with done two cycles after each grant.
      bus16.en  = 1'b1;
      bus16.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rr_gnt",     32'(bus16.gnt),      32'h1 << win[k]);
         chk("rr_owner",   32'(bus16.owner_id), 32'(win[k]));
         chk("rr_busy",    32'(bus16.busy),     32'h1);
         step();
         chk("rr_hold",    32'(bus16.gnt),      32'h1 << win[k]);
         bus16.done = 1'b1;
         step();
         bus16.done = 1'b0;
         chk("rr_bubble",  32'(bus16.gnt),      32'h0);
         chk("rr_keepown", 32'(bus16.owner_id), 32'(win[k]));
         chk("rr_tmo",     32'(bus16.timeout),  32'h0);
      end

      // Enable revoke: pointer now 3, so 2 wins.
      bus16.req = 4'b0100;
      step();
      chk("en_gnt", 32'(bus16.gnt), 32'h4);
      bus16.en = 1'b0;
      step();
      chk("en_revoke", 32'(bus16.gnt),     32'h0);
      chk("en_tmo",    32'(bus16.timeout), 32'h0);
      bus16.req = 4'b0110;
      step();
      chk("en_off1", 32'(bus16.gnt), 32'h0);
      step();
      chk("en_off2", 32'(bus16.gnt), 32'h0);
      bus16.en = 1'b1;
      step();
      chk("en_next", 32'(bus16.gnt), 32'h2);
      bus16.req = 4'b0000;
      step();
      chk("en_rel", 32'(bus16.gnt), 32'h0);

      // Park the pointer on 0 so 3 outranks 0, then the owner drops its request.
      bus16.req = 4'b0001;
      step();
      chk("drop_pre", 32'(bus16.gnt), 32'h1);
      bus16.req = 4'b0000;
      step();
      bus16.req = 4'b1001;
      step();
      chk("drop_gnt", 32'(bus16.gnt), 32'h8);
      bus16.req = 4'b0001;
      step();
      chk("drop_rel", 32'(bus16.gnt), 32'h0);
      step();
      chk("drop_next", 32'(bus16.gnt), 32'h1);
      bus16.req = 4'b0000;
      bus16.en  = 1'b0;
      step();

      // Watchdog on HOLD_MAX=4.
      bus4.en  = 1'b1;
      bus4.req = 4'b0010;
      for (int c = 1; c <= 4; c++) begin
         step();
         chk("wd_gnt", 32'(bus4.gnt),     32'h2);
         chk("wd_tmo", 32'(bus4.timeout), 32'h0);
      end
      step();
      chk("wd_rel",   32'(bus4.gnt),     32'h0);
      chk("wd_pulse", 32'(bus4.timeout), 32'h1);
      chk("wd_busy",  32'(bus4.busy),    32'h0);
      step();
      chk("wd_regnt", 32'(bus4.gnt),     32'h2);
      chk("wd_tmo0",  32'(bus4.timeout), 32'h0);

      // done coincides with counter==HOLD_MAX: plain release, no timeout.
      step();
      step();
      step();
      chk("sim_hold", 32'(bus4.gnt), 32'h2);
      bus4.done = 1'b1;
      step();
      bus4.done = 1'b0;
      chk("sim_gnt", 32'(bus4.gnt),     32'h0);
      chk("sim_tmo", 32'(bus4.timeout), 32'h0);
      bus4.req = 4'b0110;
      step();
      chk("sim_ptr", 32'(bus4.gnt), 32'h4);
      bus4.req = 4'b0000;
      step();

      // Async reset while owner 1 holds; pointer sits at 2 beforehand.
      bus4.req = 4'b0010;
      step();
      chk("ar_gnt", 32'(bus4.gnt), 32'h2);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_gnt0",   32'(bus4.gnt),      32'h0);
      chk("ar_busy0",  32'(bus4.busy),     32'h0);
      chk("ar_owner0", 32'(bus4.owner_id), 32'h0);
      chk("ar_tmo0",   32'(bus4.timeout),  32'h0);
      #1;
      reset    = 1'b0;
      bus4.req = 4'b0101;
      step();
      chk("ar_order", 32'(bus4.gnt),      32'h4);
      chk("ar_owner", 32'(bus4.owner_id), 32'h2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
